keypad_control: RTL and testbench
=================================

// Module: keypad_control
// PURPOSE
//   Consumer end of the keypad path: takes kphit/buttonNum from kpdecode, debounces them,
//   and turns each accepted key press into one event. A menu FSM applies those events to
//   the freqSelect, lowpassSelect and highpassSelect registers that drive the signal chain.
//   Also exports the edit state so the display path can show what is being changed.
// PARAMETERS
//   DEBOUNCE_CYCLES  960     consecutive stable clk_48 cycles needed to accept a press or a release
//   TIMEOUT_CYCLES   240000  idle clk_48 cycles in an edit state before returning to IDLE
// PORTS
//   clk_48          in   1  system clock (48 kHz domain)
//   reset_n         in   1  asynchronous active-low reset
//   kphit           in   1  high while any key is decoded
//   buttonNum       in   4  decoded key: 0-9 digits, 10=A, 11=B, 12=C, 13=D, 14=*, 15=#
//   freqSelect      out  3  sine generator frequency select
//   lowpassSelect   out  3  lowpass filter select
//   highpassSelect  out  3  highpass filter select
//   editMode        out  2  0 = IDLE, 1 = freq, 2 = lowpass, 3 = highpass
//   editValue       out  3  current value of the edited register; 0 in IDLE
//   keyEvent        out  1  one-cycle pulse per accepted press
//   keyErr          out  1  one-cycle pulse when digit 8 or 9 is pressed in an edit state
// BEHAVIOUR
//   Reset (async, reset_n = 0):
//   - All outputs 0; FSM = IDLE; all counters and synchronisers cleared.
//   Synchronisers:
//   - kphit and buttonNum each pass through 2 flops before use.
//   Debouncer (states UP, PRESS_WAIT, DOWN, REL_WAIT):
//   - UP -> PRESS_WAIT when synced kphit = 1; captures buttonNum; count = 1.
//   - PRESS_WAIT: count increments while kphit = 1 and buttonNum equals the capture.
//   - PRESS_WAIT: if buttonNum differs, recapture it and set count = 1.
//   - PRESS_WAIT: if kphit = 0, return to UP.
//   - PRESS_WAIT: when count reaches DEBOUNCE_CYCLES, go to DOWN; keyEvent = 1 on the next cycle with the captured key.
//   - DOWN: ignores all input until kphit = 0, then REL_WAIT.
//   - REL_WAIT: needs DEBOUNCE_CYCLES consecutive kphit = 0 to reach UP; any kphit = 1 returns to DOWN.
//   - Exactly one event per physical press; no auto-repeat.
//   Menu FSM (states IDLE, SEL_FREQ, SEL_LP, SEL_HP); consumes the event in its keyEvent cycle:
//   - IDLE: A -> SEL_FREQ, B -> SEL_LP, C -> SEL_HP; every other key is ignored.
//   - SEL_x, digit 0-7: write it to the target register, then go to IDLE.
//   - SEL_x, digit 8-9: keyErr pulses (same cycle as keyEvent); state unchanged.
//   - SEL_x, A/B/C: switch target; no register is written.
//   - SEL_x, D or *: go to IDLE with no write.
//   - SEL_x, #: target = target + 1 mod 8 (7 wraps to 0); stay in SEL_x.
//   Output timing:
//   - Register writes, editMode and editValue update on the clock edge that ends the keyEvent cycle.
//   - Total latency from the first synced kphit = 1 is DEBOUNCE_CYCLES + 2 clk_48 cycles to updated outputs.
//   Timeout:
//   - A counter runs only in SEL_x and clears on every keyEvent and on entry to SEL_x.
//   - At TIMEOUT_CYCLES: go to IDLE, no write.
//   - If timeout and keyEvent fall in the same cycle, keyEvent wins and the timeout is discarded.
//   Mid-operation reset:
//   - Aborts any pending edit.
//   - A key still held after reset is accepted as a new press once debounced.
// TESTING (bench runs DEBOUNCE_CYCLES = 4, TIMEOUT_CYCLES = 50)
//   1. Press A for 10 cycles, release; press 5 for 10 cycles.
//      -> editMode = 1 after A; then freqSelect = 5, editMode = 0, exactly 2 keyEvent pulses.
//   2. Bounce: kphit toggles 1,0,1,1,0 then holds 1 with key B.
//      -> a single keyEvent, issued 4 stable cycles after the hold starts; editMode = 2.
//   3. lowpassSelect = 7; press C, B, then # twice.
//      -> lowpassSelect = 0, then 1; editMode stays 2; C changes no register.
//   4. In SEL_HP press 9, then 3.
//      -> one keyErr pulse with no change; then highpassSelect = 3, editMode = 0.
//   5. Press A, then no input for 50 cycles.
//      -> editMode = 0 and freqSelect unchanged; a keyEvent landing on cycle 50 must still be applied.
//   6. Assert reset_n = 0 in PRESS_WAIT and in SEL_LP.
//      -> all outputs 0 immediately; held key yields one event after release of reset plus debounce.

Source files
------------

// File: rtl/keypad_control_if.sv
// Keypad decoder to keypad_control link: decoded key in, menu selections and edit status out.
interface keypad_control_if;
  logic       kphit;
  logic [3:0] buttonNum;
  logic [2:0] freqSelect;
  logic [2:0] lowpassSelect;
  logic [2:0] highpassSelect;
  logic [1:0] editMode;
  logic [2:0] editValue;
  logic       keyEvent;
  logic       keyErr;

  modport master (
    output kphit, buttonNum,
    input  freqSelect, lowpassSelect, highpassSelect, editMode, editValue, keyEvent, keyErr
  );
  modport slave (
    input  kphit, buttonNum,
    output freqSelect, lowpassSelect, highpassSelect, editMode, editValue, keyEvent, keyErr
  );
endinterface

// File: rtl/keypad_control.sv
// Debounces decoded keypad hits into one event per press and runs the select-register menu.
module keypad_control #(
  parameter int DEBOUNCE_CYCLES = 960,
  parameter int TIMEOUT_CYCLES  = 240000
) (
  input  logic           clk_48,
  input  logic           reset_n,
  keypad_control_if.slave kp
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {UP, PRESS_WAIT, DOWN, REL_WAIT} db_state_t;
  typedef enum logic [1:0] {IDLE = 2'd0, SEL_FREQ = 2'd1, SEL_LP = 2'd2, SEL_HP = 2'd3} menu_state_t;

  logic [1:0]    hit_sync;
  logic [3:0]    btn_s1, btn_s2;
  logic          hit;
  db_state_t     db_st, db_nxt;
  logic [DW-1:0] db_cnt, db_cnt_nxt;
  logic [3:0]    cap, cap_nxt;
  logic          key_event, ev_nxt;

  menu_state_t   m_st, m_nxt;
  logic [2:0]    freq, lp, hp, freq_nxt, lp_nxt, hp_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic [2:0]    cur_val;
  logic          wr, err;
  logic [2:0]    wr_val;

  assign hit = hit_sync[1];

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      hit_sync  <= '0;
      btn_s1    <= '0;
      btn_s2    <= '0;
      db_st     <= UP;
      db_cnt    <= '0;
      cap       <= '0;
      key_event <= 1'b0;
    end else begin
      hit_sync  <= {hit_sync[0], kp.kphit};
      btn_s1    <= kp.buttonNum;
      btn_s2    <= btn_s1;
      db_st     <= db_nxt;
      db_cnt    <= db_cnt_nxt;
      cap       <= cap_nxt;
      key_event <= ev_nxt;
    end
  end

  // Count reaching the limit wins over the current sample: the key already had its stable cycles.
  always_comb begin
    db_nxt     = db_st;
    db_cnt_nxt = db_cnt;
    cap_nxt    = cap;
    ev_nxt     = 1'b0;
    case (db_st)
      UP: if (hit) begin
        db_nxt     = PRESS_WAIT;
        cap_nxt    = btn_s2;
        db_cnt_nxt = DW'(1);
      end
      PRESS_WAIT: begin
        if (db_cnt == DB_MAX) begin
          db_nxt = DOWN;
          ev_nxt = 1'b1;
        end else if (!hit) begin
          db_nxt = UP;
        end else if (btn_s2 != cap) begin
          cap_nxt    = btn_s2;
          db_cnt_nxt = DW'(1);
        end else begin
          db_cnt_nxt = db_cnt + DW'(1);
        end
      end
      DOWN: if (!hit) begin
        db_nxt     = REL_WAIT;
        db_cnt_nxt = DW'(1);
      end
      REL_WAIT: begin
        if (hit)                  db_nxt = DOWN;
        else if (db_cnt == DB_MAX) db_nxt = UP;
        else                      db_cnt_nxt = db_cnt + DW'(1);
      end
      default: db_nxt = UP;
    endcase
  end

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      m_st   <= IDLE;
      freq   <= '0;
      lp     <= '0;
      hp     <= '0;
      to_cnt <= '0;
    end else begin
      m_st   <= m_nxt;
      freq   <= freq_nxt;
      lp     <= lp_nxt;
      hp     <= hp_nxt;
      to_cnt <= to_nxt;
    end
  end

  always_comb begin
    case (m_st)
      SEL_FREQ: cur_val = freq;
      SEL_LP:   cur_val = lp;
      SEL_HP:   cur_val = hp;
      default:  cur_val = 3'd0;
    endcase
  end

  // A key event always clears the idle counter, so it pre-empts a same-cycle timeout.
  always_comb begin
    m_nxt    = m_st;
    to_nxt   = '0;
    wr       = 1'b0;
    wr_val   = cur_val;
    err      = 1'b0;
    freq_nxt = freq;
    lp_nxt   = lp;
    hp_nxt   = hp;
    if (key_event) begin
      if (m_st == IDLE) begin
        case (cap)
          4'd10:   m_nxt = SEL_FREQ;
          4'd11:   m_nxt = SEL_LP;
          4'd12:   m_nxt = SEL_HP;
          default: m_nxt = IDLE;
        endcase
      end else begin
        case (cap)
          4'd8, 4'd9:          err   = 1'b1;
          4'd10:               m_nxt = SEL_FREQ;
          4'd11:               m_nxt = SEL_LP;
          4'd12:               m_nxt = SEL_HP;
          4'd13, 4'd14:        m_nxt = IDLE;
          4'd15: begin
            wr     = 1'b1;
            wr_val = cur_val + 3'd1;
          end
          default: begin
            wr     = 1'b1;
            wr_val = cap[2:0];
            m_nxt  = IDLE;
          end
        endcase
      end
    end else if (m_st != IDLE) begin
      if (to_cnt == TO_LAST) m_nxt = IDLE;
      else                   to_nxt = to_cnt + TW'(1);
    end
    if (wr) begin
      case (m_st)
        SEL_FREQ: freq_nxt = wr_val;
        SEL_LP:   lp_nxt   = wr_val;
        SEL_HP:   hp_nxt   = wr_val;
        default:  ;
      endcase
    end
  end

  assign kp.freqSelect     = freq;
  assign kp.lowpassSelect  = lp;
  assign kp.highpassSelect = hp;
  assign kp.editMode       = m_st;
  assign kp.editValue      = cur_val;
  assign kp.keyEvent       = key_event;
  assign kp.keyErr         = err;
endmodule

// File: tb/tb_keypad_control.sv
// Randomised keypad press sequences scored against a menu-level model of the key rules.
module tb_keypad_control;
  localparam int D = 4;
  localparam int T = 50;

  logic clk_48 = 1'b0;
  logic reset_n = 1'b0;
  keypad_control_if kp();

  keypad_control #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
    .clk_48 (clk_48),
    .reset_n(reset_n),
    .kp     (kp)
  );

  always #5 clk_48 = ~clk_48;

  int cyc = 0;
  always @(posedge clk_48) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [2:0] f, lp, hp;
    logic [1:0] mode;
    logic [2:0] val;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  int m_mode;
  int m_reg[4];
  int ev_count = 0, last_ev = -1;

  task automatic chk(string name, logic [31:0] act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk_48);
    #1;
  endtask

  function automatic void model_reset();
    m_mode = 0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    q.delete();
  endfunction

  // Menu rules applied to one accepted key; the expected outcome is queued for the monitor.
  function automatic void model_key(int key);
    exp_t e;
    e.err = 1'b0;
    if (m_mode == 0) begin
      if (key >= 10 && key <= 12) m_mode = key - 9;
    end else if (key <= 7) begin
      m_reg[m_mode] = key;
      m_mode = 0;
    end else if (key <= 9) begin
      e.err = 1'b1;
    end else if (key <= 12) begin
      m_mode = key - 9;
    end else if (key <= 14) begin
      m_mode = 0;
    end else begin
      m_reg[m_mode] = (m_reg[m_mode] + 1) % 8;
    end
    e.f    = 3'(m_reg[1]);
    e.lp   = 3'(m_reg[2]);
    e.hp   = 3'(m_reg[3]);
    e.mode = 2'(m_mode);
    e.val  = (m_mode == 0) ? 3'd0 : 3'(m_reg[m_mode]);
    q.push_back(e);
  endfunction

  task automatic press(int key, int hold, int rel);
    kp.kphit = 1'b1;
    kp.buttonNum = key[3:0];
    model_key(key);
    tick(hold);
    kp.kphit = 1'b0;
    kp.buttonNum = 4'($urandom_range(0, 15));
    tick(rel);
  endtask

  task automatic chk_zero(string name);
    chk({name, "_freq"}, kp.freqSelect, 0);
    chk({name, "_lp"}, kp.lowpassSelect, 0);
    chk({name, "_hp"}, kp.highpassSelect, 0);
    chk({name, "_mode"}, kp.editMode, 0);
    chk({name, "_val"}, kp.editValue, 0);
    chk({name, "_event"}, kp.keyEvent, 0);
    chk({name, "_err"}, kp.keyErr, 0);
  endtask

  // Monitor: pops one expectation per keyEvent; keyErr in the event cycle, registers one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_48);
      if (reset_n && kp.keyEvent === 1'b1) begin
        ev_count++;
        last_ev = cyc;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: keyEvent at cycle %0d with nothing expected", cyc);
        end else begin
          e = q.pop_front();
          chk("keyErr", kp.keyErr, e.err);
          @(negedge clk_48);
          chk("freqSelect", kp.freqSelect, e.f);
          chk("lowpassSelect", kp.lowpassSelect, e.lp);
          chk("highpassSelect", kp.highpassSelect, e.hp);
          chk("editMode", kp.editMode, e.mode);
          chk("editValue", kp.editValue, e.val);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int kd, ka, n0;
    int key, h, r;
    kp.kphit = 1'b0;
    kp.buttonNum = 4'd0;
    model_reset();
    tick(3);
    chk_zero("reset");
    reset_n = 1'b1;
    tick(2);

    // A then 5: edit frequency; event D+3 cycles after the drive cycle
    kd = cyc;
    press(10, 10, 10);
    chk("latency_A", last_ev, kd + D + 3);
    press(5, 10, 10);
    chk("two_events", ev_count, 2);

    // Bouncing kphit with key B, then a steady hold
    kd = cyc;
    kp.buttonNum = 4'd11;
    kp.kphit = 1'b1; tick(1);
    kp.kphit = 1'b0; tick(1);
    kp.kphit = 1'b1; tick(2);
    kp.kphit = 1'b0; tick(1);
    kp.kphit = 1'b1;
    model_key(11);
    tick(10);
    kp.kphit = 1'b0;
    tick(10);
    chk("bounce_events", ev_count, 3);
    chk("bounce_latency", last_ev, kd + 5 + D + 3);

    // lowpass = 7, then C, B, #, # wraps 7 -> 0 -> 1
    press(7, 8, 8);
    press(12, 8, 8);
    press(11, 8, 8);
    press(15, 8, 8);
    press(15, 8, 8);
    press(13, 8, 8);

    // Digit 9 errors in SEL_HP, then 3 is written
    press(12, 8, 8);
    press(9, 8, 8);
    press(3, 8, 8);

    // Idle timeout out of SEL_FREQ
    press(10, 8, 8);
    tick(T + 10);
    m_mode = 0;
    chk("timeout_mode", kp.editMode, 0);
    chk("timeout_freq", kp.freqSelect, m_reg[1]);

    // keyEvent on the last idle cycle is applied
    press(10, 8, 8);
    press(2, 8, 8);
    ka = cyc;
    press(10, 8, 8);
    while (cyc < ka + T) tick(1);
    press(5, 8, 8);
    chk("edge_event_cycle", last_ev, ka + T + D + 3);

    // One cycle later the timeout has already fired, so 5 is ignored in IDLE
    press(10, 8, 8);
    press(6, 8, 8);
    ka = cyc;
    press(10, 8, 8);
    while (cyc < ka + T + 1) tick(1);
    m_mode = 0;
    press(5, 8, 8);
    chk("late_event_cycle", last_ev, ka + T + 1 + D + 3);

    // Reset during PRESS_WAIT; the held key is re-accepted afterwards
    n0 = ev_count;
    kp.buttonNum = 4'd10;
    kp.kphit = 1'b1;
    tick(4);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_zero("rst_pw");
    tick(2);
    reset_n = 1'b1;
    model_key(10);
    tick(10);
    kp.kphit = 1'b0;
    tick(10);
    chk("rst_pw_events", ev_count, n0 + 1);

    // Reset while in SEL_LP aborts the edit
    press(11, 8, 8);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_zero("rst_sel");
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Random presses with occasional long idles
    for (int i = 0; i < 40; i++) begin
      key = $urandom_range(0, 15);
      h = $urandom_range(6, 10);
      r = $urandom_range(8, 12);
      press(key, h, r);
      if ($urandom_range(0, 7) == 0) begin
        tick(T + 10);
        m_mode = 0;
        chk("rand_timeout_mode", kp.editMode, 0);
      end
    end

    for (int i = 0; i < 100 && q.size() != 0; i++) tick(1);
    chk("queue_drained", q.size(), 0);
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
